// File: rtl/ahbl_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_splitter_n
// Description : AHB-Lite address decoder and response multiplexer for
//               NUM_SLAVES slaves, with a built-in default slave.
//               - Decodes HADDR against base/mask pairs. The lowest index
//                 wins when slave regions overlap.
//               - Steers HREADY/HRESP/HRDATA from the slave that owns the
//                 current data phase.
//               - Answers unmapped active transfers with a two-cycle ERROR
//                 response.
//               - Records the address of the last unmapped transfer and a
//                 saturating count of the ERROR responses it issued.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_splitter_n #(
  parameter int                         NUM_SLAVES = 3,
  parameter int                         DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {3{32'hF000_0000}}
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  // master address phase
  input  logic [31:0]                      HADDR,
  input  logic [1:0]                       HTRANS,
  // muxed response to the master
  output logic                             HREADY,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  // slave side
  output logic [NUM_SLAVES-1:0]            S_HSEL,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]            S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]            S_HRESP,
  // default-slave diagnostics
  output logic [7:0]                       err_count,
  output logic [31:0]                      err_addr
);

  // Slave index width. It is kept at least 1 bit wide so that a
  // single-slave build still has a legal vector.
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [NUM_SLAVES-1:0] w_match;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
    assign w_match[gi] = ((HADDR & SLAVE_MASK[32*gi +: 32]) ==
                          (SLAVE_BASE[32*gi +: 32] & SLAVE_MASK[32*gi +: 32]));
  end

  // Priority encode the matches. The scan runs from the top index down, so
  // the lowest matching index is written last and wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  // Select follows HADDR alone. HTRANS gating is left to the slaves.
  always_comb begin
    S_HSEL = '0;
    if (w_hit) begin
      S_HSEL = NUM_SLAVES'(1) << w_idx;
    end
  end

  // Only the "active" bit of HTRANS matters to the splitter. BUSY and IDLE
  // are treated alike.
  logic w_addr_active;
  logic w_unused_htrans0;
  assign w_addr_active    = HTRANS[1];
  assign w_unused_htrans0 = HTRANS[0];

  // --------------------------------------------------------------------------
  // Data-phase state
  // --------------------------------------------------------------------------
  logic                  r_dp_valid;
  logic [IDX_W-1:0]      r_dp_idx;
  ds_state_e             r_ds_state;
  ds_state_e             w_ds_next;
  logic [7:0]            r_err_count;
  logic [31:0]           r_err_addr;

  logic                  w_hready;
  logic                  w_hresp;
  logic [DATA_WIDTH-1:0] w_hrdata;

  logic                  w_s_ready;
  logic                  w_s_resp;
  logic [DATA_WIDTH-1:0] w_s_rdata;

  // An active address phase to an unmapped address is accepted on this edge.
  logic w_unmapped_req;
  assign w_unmapped_req = w_hready & w_addr_active & ~w_hit;

  // Pick the response of the slave that owns the current data phase.
  always_comb begin
    w_s_ready = 1'b1;
    w_s_resp  = 1'b0;
    w_s_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_dp_idx == IDX_W'(i)) begin
        w_s_ready = S_HREADYOUT[i];
        w_s_resp  = S_HRESP[i];
        w_s_rdata = S_HRDATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Drive the master-facing response. An error state takes precedence over
  // the slave mux. Otherwise an idle data phase completes as zero-wait OKAY.
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = '0;
    unique case (r_ds_state)
      DS_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = 1'b1;
      end
      DS_ERR2: begin
        w_hresp  = 1'b1;
      end
      default: begin
        if (r_dp_valid) begin
          w_hready = w_s_ready;
          w_hresp  = w_s_resp;
          w_hrdata = w_s_rdata;
        end
      end
    endcase
  end

  assign HREADY = w_hready;
  assign HRESP  = w_hresp;
  assign HRDATA = w_hrdata;

  // Next state of the default slave. ERR1 is a forced wait cycle. ERR2 is
  // the completing cycle, and there the next address phase is decoded again.
  always_comb begin
    w_ds_next = r_ds_state;
    unique case (r_ds_state)
      DS_OK:   if (w_unmapped_req) w_ds_next = DS_ERR1;
      DS_ERR1: w_ds_next = DS_ERR2;
      DS_ERR2: w_ds_next = w_unmapped_req ? DS_ERR1 : DS_OK;
      default: w_ds_next = DS_OK;
    endcase
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ds_state <= DS_OK;
    end else begin
      r_ds_state <= w_ds_next;
    end
  end

  // Capture the data-phase owner whenever an address phase is accepted.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_idx   <= '0;
    end else if (w_hready) begin
      r_dp_valid <= w_addr_active & w_hit;
      r_dp_idx   <= w_idx;
    end
  end

  // Latch the offending address when an error response starts.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_addr <= 32'h0;
    end else if (w_unmapped_req) begin
      r_err_addr <= HADDR;
    end
  end

  // Count each completed error response. The count stops at all-ones.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_count <= 8'h00;
    end else if ((r_ds_state == DS_ERR2) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'h01;
    end
  end

  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_splitter_n
// Description : Self-checking bench for ahbl_splitter_n with four slaves.
//               Each accepted address phase pushes its expected data-phase
//               cycles onto a scoreboard. Each clock pops one entry, drives
//               the owning slave and compares the muxed outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_splitter_n;

  localparam logic [127:0] TB_BASE = {32'h5000_0000, 32'h4001_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [127:0] TB_MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

  logic         HCLK;
  logic         HRESET;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [3:0]   S_HSEL;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HREADYOUT;
  logic [3:0]   S_HRESP;
  logic [7:0]   err_count;
  logic [31:0]  err_addr;

  ahbl_splitter_n #(
    .NUM_SLAVES (4),
    .DATA_WIDTH (32),
    .SLAVE_BASE (TB_BASE),
    .SLAVE_MASK (TB_MASK)
  ) u_dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .S_HSEL      (S_HSEL),
    .S_HRDATA    (S_HRDATA),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .err_count   (err_count),
    .err_addr    (err_addr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One data-phase cycle: what the owning slave drives and what the master
  // must see.
  typedef struct {
    int          slv;
    logic        s_rdy;
    logic        s_rsp;
    logic [31:0] s_dat;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_dat;
  } dp_t;

  dp_t         sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [7:0]  exp_cnt   = 8'h00;
  logic [31:0] exp_eaddr = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic dp_t mk(input int slv, input logic s_rdy, input logic s_rsp,
                             input logic [31:0] s_dat, input logic e_rdy,
                             input logic e_rsp, input logic [31:0] e_dat);
    dp_t d;
    d.slv = slv; d.s_rdy = s_rdy; d.s_rsp = s_rsp; d.s_dat = s_dat;
    d.e_rdy = e_rdy; d.e_rsp = e_rsp; d.e_dat = e_dat;
    return d;
  endfunction

  // Reference decode: lowest matching index, -1 when unmapped.
  function automatic int exp_idx(input logic [31:0] a);
    logic [127:0] b;
    logic [127:0] m;
    int r;
    b = TB_BASE;
    m = TB_MASK;
    r = -1;
    for (int i = 3; i >= 0; i--) begin
      if ((a & m[32*i +: 32]) == (b[32*i +: 32] & m[32*i +: 32])) r = i;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [31:0] a);
    int s;
    s = exp_idx(a);
    return (s < 0) ? 4'b0000 : 4'(1 << s);
  endfunction

  // Non-owning slaves drive hostile values so any wrong steering shows up.
  task automatic drive_slaves(input dp_t e);
    for (int i = 0; i < 4; i++) begin
      if (i == e.slv) begin
        S_HREADYOUT[i]       = e.s_rdy;
        S_HRESP[i]           = e.s_rsp;
        S_HRDATA[32*i +: 32] = e.s_dat;
      end else begin
        S_HREADYOUT[i]       = 1'b0;
        S_HRESP[i]           = 1'b1;
        S_HRDATA[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
      end
    end
  endtask

  // Run one clock. Drive the current data phase, then check at negedge.
  task automatic run_cycle(output logic rdy);
    dp_t e;
    if (sb.size() != 0) e = sb[0];
    else                e = mk(-1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_slaves(e);
    @(negedge HCLK);
    if (sb.size() != 0) void'(sb.pop_front());
    check_val("hsel",   32'(S_HSEL), 32'(exp_sel(HADDR)));
    check_val("hready", 32'(HREADY), 32'(e.e_rdy));
    check_val("hresp",  32'(HRESP),  32'(e.e_rsp));
    check_val("hrdata", HRDATA,      e.e_dat);
    rdy = e.e_rdy;
    @(posedge HCLK);
    #1;
  endtask

  // Queue the data-phase cycles that an accepted address phase should produce.
  task automatic push_expect(input logic [31:0] addr, input logic [1:0] trans,
                             input int waits, input logic rsp, input logic [31:0] dat);
    int s;
    s = exp_idx(addr);
    if (!trans[1]) begin
      sb.push_back(mk(-1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
    end else if (s < 0) begin
      sb.push_back(mk(-1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0));
      sb.push_back(mk(-1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0));
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
      exp_eaddr = addr;
    end else begin
      for (int k = 0; k < waits; k++) begin
        logic r;
        r = (k == waits - 1) ? rsp : 1'b0;
        sb.push_back(mk(s, 1'b0, r, dat, 1'b0, r, dat));
      end
      sb.push_back(mk(s, 1'b1, rsp, dat, 1'b1, rsp, dat));
    end
  endtask

  // Present an address phase and hold it until the previous data phase ends.
  task automatic issue(input logic [31:0] addr, input logic [1:0] trans, input int waits,
                       input logic rsp, input logic [31:0] dat, input bit idle_after_first);
    logic rdy;
    HADDR  = addr;
    HTRANS = trans;
    run_cycle(rdy);
    while (!rdy) begin
      if (idle_after_first) HTRANS = 2'b00;
      run_cycle(rdy);
    end
    push_expect(HADDR, HTRANS, waits, rsp, dat);
  endtask

  task automatic check_err_regs(input string tag);
    check_val({tag, "_cnt"},  32'(err_count), 32'(exp_cnt));
    check_val({tag, "_addr"}, err_addr,       exp_eaddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1;
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    drive_slaves(mk(-1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
    #3;
    check_val("rst_hready", 32'(HREADY), 32'h1);
    check_val("rst_hresp",  32'(HRESP),  32'h0);
    check_val("rst_hrdata", HRDATA,      32'h0);
    check_err_regs("rst");
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Overlapping regions: slave1 beats slave2. Read data arrives next cycle.
    HADDR = 32'h4001_0004;
    #1;
    check_val("sel_overlap", 32'(S_HSEL), 32'h2);
    issue(32'h4001_0004, 2'b10, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Unmapped address followed by an IDLE transfer.
    issue(32'h7000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0100, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("single_err");
    check_val("single_err_cnt1", 32'(err_count), 32'h1);

    // Slave3 inserts two wait states and then responds with ERROR.
    issue(32'h5000_0010, 2'b10, 2, 1'b1, 32'h1234_5678, 1'b0);
    issue(32'h0000_0040, 2'b11, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Back-to-back unmapped transfers.
    issue(32'h7000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h8000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("b2b");

    // The master drops to IDLE during ERR1. The error response still runs
    // for both cycles.
    issue(32'h7000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h4000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b1);
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("idle_in_err1");

    // An IDLE transfer to an unmapped address does not raise an error.
    issue(32'h7000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("idle_unmapped");

    // The error counter saturates.
    for (int i = 0; i < 300; i++) begin
      issue(32'h9000_0000 | (32'(i) << 2), 2'b10, 0, 1'b0, 32'h0, 1'b0);
    end
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("saturate");
    check_val("saturate_ff", 32'(err_count), 32'hFF);

    // Reset pulse during ERR1.
    issue(32'h7000_0000, 2'b10, 0, 1'b0, 32'h0, 1'b0);
    HTRANS = 2'b00;
    #2;
    HRESET = 1'b1;
    #1;
    check_val("rst_err1_hready", 32'(HREADY), 32'h1);
    check_val("rst_err1_hresp",  32'(HRESP),  32'h0);
    exp_cnt   = 8'h00;
    exp_eaddr = 32'h0;
    check_err_regs("rst_err1");
    sb.delete();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    // The first transfer after release is accepted on the very next edge.
    issue(32'h4001_0004, 2'b10, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0000, 2'b00, 0, 1'b0, 32'h0, 1'b0);
    check_err_regs("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
